// File: rtl/bf_fetch_unit.sv
// ============================================================================
// Module   : bf_fetch_unit
// Brief    : Brainfuck fetch/decode stage with bracket-matching ROM scan.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_fetch_unit #(
  parameter int ADDR_W  = 4,
  parameter int DEPTH_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [7:0]        romData,
  output logic [7:0]        instrOut,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              cellZero,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              error
);

  localparam logic [ADDR_W-1:0]  PC_TOP    = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0]  PC_ZERO   = '0;
  localparam logic [DEPTH_W-1:0] DEPTH_TOP = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_CLOSE = 8'h5D;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_SCAN_F = 3'd3,
    S_SCAN_B = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [7:0]         instr_q;
  logic               valid_q;
  logic               halted_q;
  logic               error_q;
  logic               scan_dec_q;

  logic w_is_op;
  logic w_rd_zero;
  logic w_rd_open;
  logic w_rd_close;
  logic w_at_top;
  logic w_at_bottom;
  logic w_depth_full;
  logic w_depth_last;
  logic w_accept;

  assign w_is_op = (romData == OP_INC)  || (romData == OP_DEC)   ||
                   (romData == OP_LEFT) || (romData == OP_RIGHT) ||
                   (romData == OP_OUT)  || (romData == OP_IN)    ||
                   (romData == OP_OPEN) || (romData == OP_CLOSE);

  assign w_rd_zero    = (romData == 8'h00);
  assign w_rd_open    = (romData == OP_OPEN);
  assign w_rd_close   = (romData == OP_CLOSE);
  assign w_at_top     = (pc_q == PC_TOP);
  assign w_at_bottom  = (pc_q == PC_ZERO);
  assign w_depth_full = (depth_q == DEPTH_TOP);
  assign w_depth_last = (depth_q == DEPTH_ONE);
  assign w_accept     = valid_q & instrReady;

  // romAddr tracks pc so the ROM is already addressed when FETCH is entered.
  assign romAddr    = pc_q;
  assign pc         = pc_q;
  assign instrOut   = instr_q;
  assign instrValid = valid_q;
  assign halted     = halted_q;
  assign error      = error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      depth_q    <= '0;
      instr_q    <= 8'h00;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
      scan_dec_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          state_q <= S_DECODE;
        end

        S_DECODE: begin
          if (w_rd_zero) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (!w_is_op) begin
            if (w_at_top) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= S_FETCH;
            end
          end else begin
            instr_q <= romData;
            valid_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (w_accept) begin
            valid_q <= 1'b0;
            if ((instr_q == OP_OPEN) && cellZero) begin
              depth_q    <= DEPTH_ONE;
              scan_dec_q <= 1'b0;
              if (w_at_top) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
                error_q  <= 1'b1;
              end else begin
                pc_q    <= pc_q + 1'b1;
                state_q <= S_SCAN_F;
              end
            end else if ((instr_q == OP_CLOSE) && !cellZero) begin
              depth_q    <= DEPTH_ONE;
              scan_dec_q <= 1'b0;
              if (w_at_bottom) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
                error_q  <= 1'b1;
              end else begin
                pc_q    <= pc_q - 1'b1;
                state_q <= S_SCAN_B;
              end
            end else if (w_at_top) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end

        // Scans alternate an address cycle and a data cycle, like FETCH/DECODE.
        S_SCAN_F: begin
          scan_dec_q <= ~scan_dec_q;
          if (scan_dec_q) begin
            if (w_rd_zero) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
              error_q  <= 1'b1;
            end else if (w_rd_open && w_depth_full) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
              error_q  <= 1'b1;
            end else if (w_rd_close && w_depth_last) begin
              depth_q <= '0;
              if (w_at_top) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
              end else begin
                pc_q    <= pc_q + 1'b1;
                state_q <= S_FETCH;
              end
            end else begin
              if (w_rd_open) begin
                depth_q <= depth_q + 1'b1;
              end else if (w_rd_close) begin
                depth_q <= depth_q - 1'b1;
              end
              if (w_at_top) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
                error_q  <= 1'b1;
              end else begin
                pc_q <= pc_q + 1'b1;
              end
            end
          end
        end

        // On the matching '[' the loop body starts right after it.
        S_SCAN_B: begin
          scan_dec_q <= ~scan_dec_q;
          if (scan_dec_q) begin
            if (w_rd_close && w_depth_full) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
              error_q  <= 1'b1;
            end else if (w_rd_open && w_depth_last) begin
              depth_q <= '0;
              pc_q    <= pc_q + 1'b1;
              state_q <= S_FETCH;
            end else begin
              if (w_rd_close) begin
                depth_q <= depth_q + 1'b1;
              end else if (w_rd_open) begin
                depth_q <= depth_q - 1'b1;
              end
              if (w_at_bottom) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
                error_q  <= 1'b1;
              end else begin
                pc_q <= pc_q - 1'b1;
              end
            end
          end
        end

        S_HALT: begin
          valid_q <= 1'b0;
        end

        default: begin
          state_q <= S_HALT;
          halted_q <= 1'b1;
          error_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bf_fetch_unit.sv
// ============================================================================
// Module   : tb_bf_fetch_unit
// Brief    : Randomized bench for bf_fetch_unit against a program-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bf_fetch_unit;

  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] romAddr;
  logic [7:0] romData;
  logic [7:0] instrOut;
  logic       instrValid;
  logic       instrReady;
  logic       cellZero;
  logic [3:0] pc;
  logic       halted;
  logic       error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rom [16];
  bit         cz [64];
  logic [7:0] exp_instr [64];
  logic [3:0] exp_pc [64];
  int         exp_n;
  bit         exp_halt;
  bit         exp_err;

  always #5 clk = ~clk;

  always @(posedge clk) romData <= rom[romAddr];

  bf_fetch_unit #(.ADDR_W(4), .DEPTH_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .romAddr    (romAddr),
    .romData    (romData),
    .instrOut   (instrOut),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .cellZero   (cellZero),
    .pc         (pc),
    .halted     (halted),
    .error      (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_op(input logic [7:0] b);
    return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D};
  endfunction

  // Program-level reference: walk the program, matching brackets by scanning.
  task automatic model_run(input int max_iss);
    int pc_m;
    int p;
    int d;
    bit fin;
    bit scanning;
    bit c;
    logic [7:0] b;
    pc_m = 0; fin = 0;
    exp_n = 0; exp_halt = 0; exp_err = 0;
    while (!fin && exp_n < max_iss) begin
      b = rom[pc_m];
      if (b == 8'h00) begin
        exp_halt = 1; fin = 1;
      end else if (!is_op(b)) begin
        if (pc_m == 15) begin exp_halt = 1; fin = 1; end
        else pc_m++;
      end else begin
        exp_instr[exp_n] = b;
        exp_pc[exp_n]    = pc_m[3:0];
        c = cz[exp_n];
        exp_n++;
        if (b == 8'h5B && c) begin
          d = 1; p = pc_m; scanning = 1;
          while (scanning) begin
            if (p == 15) begin
              exp_halt = 1; exp_err = 1; fin = 1; scanning = 0;
            end else begin
              p++;
              if (rom[p] == 8'h00) begin
                exp_halt = 1; exp_err = 1; fin = 1; scanning = 0;
              end else if (rom[p] == 8'h5B) begin
                if (d == 15) begin exp_halt = 1; exp_err = 1; fin = 1; scanning = 0; end
                else d++;
              end else if (rom[p] == 8'h5D) begin
                d--;
                if (d == 0) begin
                  scanning = 0;
                  if (p == 15) begin exp_halt = 1; fin = 1; end
                  else pc_m = p + 1;
                end
              end
            end
          end
        end else if (b == 8'h5D && !c) begin
          d = 1; p = pc_m; scanning = 1;
          while (scanning) begin
            if (p == 0) begin
              exp_halt = 1; exp_err = 1; fin = 1; scanning = 0;
            end else begin
              p--;
              if (rom[p] == 8'h5D) begin
                if (d == 15) begin exp_halt = 1; exp_err = 1; fin = 1; scanning = 0; end
                else d++;
              end else if (rom[p] == 8'h5B) begin
                d--;
                if (d == 0) begin scanning = 0; pc_m = p + 1; end
              end
            end
          end
        end else begin
          if (pc_m == 15) begin exp_halt = 1; fin = 1; end
          else pc_m++;
        end
      end
    end
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < 16; i++) rom[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  task automatic fill_cz(input int mode);
    for (int i = 0; i < 64; i++) begin
      if (mode == 0) cz[i] = 1'b0;
      else if (mode == 1) cz[i] = (i == 0);
      else cz[i] = $urandom_range(0, 1) != 0;
    end
  endtask

  task automatic load_random();
    logic [7:0] ops [8];
    ops = '{8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D};
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 19))
        0:       rom[i] = 8'h00;
        1:       rom[i] = 8'h61;
        default: rom[i] = ops[$urandom_range(0, 7)];
      endcase
    end
  endtask

  task automatic run_test(input string name, input int max_iss, input bit stall_start);
    int  idx;
    int  cyc;
    int  stalls;
    bit  acc_prev;
    bit  done;
    bit  r;
    model_run(max_iss);
    reset_n = 1'b0; instrReady = 1'b0; cellZero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({name, ":rst_valid"}, instrValid, 0);
    check({name, ":rst_romAddr"}, romAddr, 0);
    check({name, ":rst_halted"}, halted, 0);
    check({name, ":rst_error"}, error, 0);
    reset_n = 1'b1;
    idx = 0; cyc = 0; stalls = 0; acc_prev = 0; done = 0;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (acc_prev) check({name, ":valid_drop"}, instrValid, 0);
      acc_prev = 0;
      if (instrValid) begin
        if (idx >= exp_n) begin
          check({name, ":extra_issue"}, idx, exp_n);
          done = 1;
        end else begin
          check({name, ":instr"}, instrOut, exp_instr[idx]);
          check({name, ":pc"}, pc, exp_pc[idx]);
          check({name, ":romAddr"}, romAddr, exp_pc[idx]);
          r = $urandom_range(0, 3) != 0;
          if (stall_start && stalls < 6) begin r = 0; stalls++; end
          instrReady = r;
          cellZero   = cz[idx];
          if (r) begin idx++; acc_prev = 1; end
          if (!exp_halt && idx == exp_n) done = 1;
        end
      end else begin
        instrReady = $urandom_range(0, 1) != 0;
        cellZero   = $urandom_range(0, 1) != 0;
      end
      if (halted) done = 1;
    end
    check({name, ":finished"}, done, 1);
    check({name, ":issues"}, idx, exp_n);
    if (exp_halt) begin
      check({name, ":halted"}, halted, 1);
      check({name, ":error"}, error, exp_err);
      check({name, ":halt_valid"}, instrValid, 0);
    end else begin
      check({name, ":not_halted"}, halted, 0);
    end
    @(posedge clk);
    instrReady = 1'b0;
  endtask

  task automatic async_reset_test();
    int w;
    load_str("[++++++++++++++]");
    reset_n = 1'b0; instrReady = 1'b0; cellZero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    w = 0;
    while (!instrValid && w < 20) begin @(negedge clk); w++; end
    check("arst:first_valid", instrValid, 1);
    instrReady = 1'b1; cellZero = 1'b1;
    @(posedge clk);
    #1 instrReady = 1'b0; cellZero = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("arst:scan_addr", romAddr, 3);
    reset_n = 1'b0;
    #1;
    check("arst:romAddr", romAddr, 0);
    check("arst:pc", pc, 0);
    check("arst:instrOut", instrOut, 0);
    check("arst:valid", instrValid, 0);
    check("arst:halted", halted, 0);
    check("arst:error", error, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("arst:restart_addr", romAddr, 0);
  endtask

  initial begin
    reset_n = 1'b0; instrReady = 1'b0; cellZero = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    load_str("+[.+]");            fill_cz(0); run_test("loop", 12, 0);
    load_str("[+[-]].");          fill_cz(1); run_test("skip_fwd", 20, 0);
    load_str("+a -");             fill_cz(0); run_test("junk_stall", 20, 1);
    load_str("++-]");             fill_cz(0); run_test("unmatched_b", 20, 0);
    load_str("[[[[[[[[[[[[[[[["); fill_cz(1); run_test("nest_ovf", 20, 0);
    load_str("++++++++++++++++"); fill_cz(0); run_test("top_end", 20, 0);
    async_reset_test();

    for (int t = 0; t < 40; t++) begin
      load_random();
      fill_cz(2);
      run_test("rand", 30, t[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
